clock_control_logic_gate: RTL and testbench
===========================================

// Module: clock_control_logic_gate
// PURPOSE
//  Control FSM for one clock-gate slice, placed directly downstream of the divider stage.
//  Its parent_* port connects to the divider's child_* port.
//  Arbitrates a child clock request, brings the parent clock up, then enables the gate hard macro.
//  Shutdown runs in reverse order: gate off first, then the parent is released.
//  async_enable/async_enable_ack form a 4-phase handshake; the ack is synchronised in this block.
// PARAMETERS
//  SYNC_STAGES   2    flops in the async_enable_ack synchroniser (>=2)
//  ACK_TIMEOUT   256  cycles to wait for a synced ack edge before setting fault (>=2)
// PORTS
//  clock             in   1  single clock for all logic
//  resetn            in   1  reset: synchronous, active-low
//  parent_request    out  1  request that the upstream (divider) clock runs
//  parent_ready      in   1  upstream clock is running and stable
//  parent_silent     in   1  upstream clock is fully stopped
//  parent_starting   in   1  upstream is ramping (status only, not used by the FSM)
//  parent_stopping   in   1  upstream is shutting down (status only)
//  child_request     in   1  consumer wants the gated clock
//  child_ready       out  1  gated clock running
//  child_silent      out  1  gated clock stopped
//  child_starting    out  1  start-up in progress
//  child_stopping    out  1  shutdown in progress
//  async_enable      out  1  gate-macro enable, registered and glitch-free
//  async_enable_ack  in   1  gate-macro ack, asynchronous to clock
//  fault             out  1  sticky error flag
//  state_dbg         out  3  current FSM state encoding
// BEHAVIOUR
//  Reset (resetn=0 at a clock edge):
//   - state=OFF, child_silent=1; all other outputs 0
//   - synchroniser and timeout counter cleared; fault cleared
//  States and transitions (one per cycle, registered outputs):
//   OFF:       child_request=1 -> REQ_PARENT
//   REQ_PARENT: parent_request=1
//              child_request=0 -> RELEASE (abort)
//              else parent_ready=1 -> ENABLING
//   ENABLING:  async_enable=1; wait for ack_sync=1 -> ON
//              child_request drop is ignored until ack arrives, then -> DISABLING
//   ON:        child_request=0 -> DISABLING
//              parent_ready=0 -> DISABLING and fault<=1
//   DISABLING: async_enable=0; wait for ack_sync=0 -> RELEASE
//   RELEASE:   parent_request=0; wait for parent_silent=1 -> OFF
//  Output decode, exactly one child_* flag high in every state:
//   - silent: OFF
//   - starting: REQ_PARENT, ENABLING
//   - ready: ON
//   - stopping: DISABLING, RELEASE
//  parent_request is 1 in REQ_PARENT, ENABLING, ON, DISABLING.
//  async_enable is 1 in ENABLING and ON only.
//  child_request re-asserted during DISABLING/RELEASE: shutdown completes to OFF, then restarts.
//  Ack sync: ack_sync = async_enable_ack delayed SYNC_STAGES clocks; the FSM uses ack_sync only.
//  Timeout counter:
//   - cleared on entry to ENABLING/DISABLING; increments each cycle while waiting
//   - saturates at ACK_TIMEOUT-1
//   - on reaching ACK_TIMEOUT-1: fault<=1, state holds and keeps waiting (no auto-recovery)
//  fault: sticky until resetn=0; it does not block normal transitions.
//  Reset mid-operation: async_enable and parent_request drop on the same edge.
//   The gate macro must tolerate an unacked enable drop.
// TESTING
//  1. Reset -> child_silent=1; parent_request=async_enable=fault=0; state_dbg=OFF.
//  2. child_request=1 at c0; parent_ready=1 at c3; ack follows enable after 1 clk:
//     parent_request at c1, async_enable at c4, child_ready at c4+1+SYNC_STAGES.
//  3. From ON drop child_request, with ack and parent_silent following:
//     async_enable=0 next cycle; parent_request=0 only after ack_sync=0;
//     child_silent once parent_silent=1.
//  4. child_request pulse of 1 cycle, parent_ready never set -> REQ_PARENT -> RELEASE -> OFF; async_enable never 1.
//  5. ACK_TIMEOUT=8, ack tied 0 -> fault=1 exactly 8 cycles after entering ENABLING; state stays ENABLING.
//  6. In ON drop parent_ready -> fault=1, child_stopping=1, async_enable=0 next cycle;
//     then assert resetn=0 in DISABLING -> all reset values on the next edge.

Source files
------------

// File: rtl/clock_control_logic_gate.sv
// Control FSM for one clock-gate slice: requests the parent clock, then drives the gate macro
// through a 4-phase enable/ack handshake, and tears down in reverse order.
module clock_control_logic_gate #(
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = 256
) (
    input  logic       clock,
    input  logic       resetn,
    output logic       parent_request,
    input  logic       parent_ready,
    input  logic       parent_silent,
    input  logic       parent_starting,
    input  logic       parent_stopping,
    input  logic       child_request,
    output logic       child_ready,
    output logic       child_silent,
    output logic       child_starting,
    output logic       child_stopping,
    output logic       async_enable,
    input  logic       async_enable_ack,
    output logic       fault,
    output logic [2:0] state_dbg
);

    localparam int                CNT_W   = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_OFF        = 3'd0,
        ST_REQ_PARENT = 3'd1,
        ST_ENABLING   = 3'd2,
        ST_ON         = 3'd3,
        ST_DISABLING  = 3'd4,
        ST_RELEASE    = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fault_q, fault_d;
    logic               waiting;
    logic [SYNC_STAGES-1:0] sync_q;
    logic               ack_sync;

    logic parent_request_q, parent_request_d;
    logic async_enable_q, async_enable_d;
    logic child_ready_q, child_ready_d;
    logic child_silent_q, child_silent_d;
    logic child_starting_q, child_starting_d;
    logic child_stopping_q, child_stopping_d;

    // Upstream ramp/stop status is informational only.
    logic status_unused;
    assign status_unused = parent_starting ^ parent_stopping;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clock) begin
                if (!resetn) begin
                    sync_q[gi] <= 1'b0;
                end else if (gi == 0) begin
                    sync_q[gi] <= async_enable_ack;
                end else begin
                    sync_q[gi] <= sync_q[(gi == 0) ? 0 : gi-1];
                end
            end
        end
    endgenerate

    assign ack_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        waiting = 1'b0;

        case (state_q)
            ST_OFF: begin
                if (child_request) state_d = ST_REQ_PARENT;
            end
            ST_REQ_PARENT: begin
                if (!child_request)    state_d = ST_RELEASE;
                else if (parent_ready) state_d = ST_ENABLING;
            end
            ST_ENABLING: begin
                // A dropped request cannot abort an unacknowledged enable.
                if (ack_sync) state_d = child_request ? ST_ON : ST_DISABLING;
                else          waiting = 1'b1;
            end
            ST_ON: begin
                if (!parent_ready) begin
                    state_d = ST_DISABLING;
                    fault_d = 1'b1;
                end else if (!child_request) begin
                    state_d = ST_DISABLING;
                end
            end
            ST_DISABLING: begin
                if (!ack_sync) state_d = ST_RELEASE;
                else           waiting = 1'b1;
            end
            ST_RELEASE: begin
                if (parent_silent) state_d = ST_OFF;
            end
            default: state_d = ST_OFF;
        endcase

        // Timeout flags fault once the counter has sat at its ceiling for a cycle; no recovery.
        if (waiting) begin
            if (cnt_q == CNT_MAX) fault_d = 1'b1;
            else                  cnt_d   = cnt_q + CNT_W'(1);
        end
        if ((state_d != state_q) && ((state_d == ST_ENABLING) || (state_d == ST_DISABLING))) begin
            cnt_d = '0;
        end
    end

    always_comb begin
        parent_request_d = (state_d == ST_REQ_PARENT) || (state_d == ST_ENABLING) ||
                           (state_d == ST_ON) || (state_d == ST_DISABLING);
        async_enable_d   = (state_d == ST_ENABLING) || (state_d == ST_ON);
        child_ready_d    = (state_d == ST_ON);
        child_silent_d   = (state_d == ST_OFF);
        child_starting_d = (state_d == ST_REQ_PARENT) || (state_d == ST_ENABLING);
        child_stopping_d = (state_d == ST_DISABLING) || (state_d == ST_RELEASE);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q          <= ST_OFF;
            cnt_q            <= '0;
            fault_q          <= 1'b0;
            parent_request_q <= 1'b0;
            async_enable_q   <= 1'b0;
            child_ready_q    <= 1'b0;
            child_silent_q   <= 1'b1;
            child_starting_q <= 1'b0;
            child_stopping_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            fault_q          <= fault_d;
            parent_request_q <= parent_request_d;
            async_enable_q   <= async_enable_d;
            child_ready_q    <= child_ready_d;
            child_silent_q   <= child_silent_d;
            child_starting_q <= child_starting_d;
            child_stopping_q <= child_stopping_d;
        end
    end

    assign parent_request = parent_request_q;
    assign async_enable   = async_enable_q;
    assign child_ready    = child_ready_q;
    assign child_silent   = child_silent_q;
    assign child_starting = child_starting_q;
    assign child_stopping = child_stopping_q;
    assign fault          = fault_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_clock_control_logic_gate.sv
// Cycle-table bench for clock_control_logic_gate: each row drives inputs for one edge and
// queues the expected state, fault and decoded output flags for that edge.
`timescale 1ns/1ps
module tb_clock_control_logic_gate;

    localparam logic [2:0] S_OFF = 3'd0;
    localparam logic [2:0] S_REQ = 3'd1;
    localparam logic [2:0] S_ENA = 3'd2;
    localparam logic [2:0] S_ON  = 3'd3;
    localparam logic [2:0] S_DIS = 3'd4;
    localparam logic [2:0] S_REL = 3'd5;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       parent_request;
    logic       parent_ready = 1'b0;
    logic       parent_silent = 1'b1;
    logic       parent_starting = 1'b0;
    logic       parent_stopping = 1'b0;
    logic       child_request = 1'b0;
    logic       child_ready;
    logic       child_silent;
    logic       child_starting;
    logic       child_stopping;
    logic       async_enable;
    logic       async_enable_ack = 1'b0;
    logic       fault;
    logic [2:0] state_dbg;

    clock_control_logic_gate #(
        .SYNC_STAGES(2),
        .ACK_TIMEOUT(8)
    ) dut (
        .clock            (clock),
        .resetn           (resetn),
        .parent_request   (parent_request),
        .parent_ready     (parent_ready),
        .parent_silent    (parent_silent),
        .parent_starting  (parent_starting),
        .parent_stopping  (parent_stopping),
        .child_request    (child_request),
        .child_ready      (child_ready),
        .child_silent     (child_silent),
        .child_starting   (child_starting),
        .child_stopping   (child_stopping),
        .async_enable     (async_enable),
        .async_enable_ack (async_enable_ack),
        .fault            (fault),
        .state_dbg        (state_dbg)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rstn;
        logic       creq;
        logic       pready;
        logic       psilent;
        logic       ack;
        logic [2:0] st;
        logic       flt;
    } vec_t;

    typedef struct {
        int         idx;
        logic [2:0] st;
        logic       flt;
        logic [5:0] flags;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // {parent_request, async_enable, child_ready, child_silent, child_starting, child_stopping}
    function automatic logic [5:0] exp_flags(input logic [2:0] st);
        case (st)
            S_OFF:   return 6'b000100;
            S_REQ:   return 6'b100010;
            S_ENA:   return 6'b110010;
            S_ON:    return 6'b111000;
            S_DIS:   return 6'b100001;
            S_REL:   return 6'b000001;
            default: return 6'b000000;
        endcase
    endfunction

    task automatic v(input logic rstn, input logic creq, input logic pr, input logic ps,
                     input logic ack, input logic [2:0] st, input logic flt);
        vec_t r;
        r.rstn = rstn; r.creq = creq; r.pready = pr; r.psilent = ps; r.ack = ack;
        r.st = st; r.flt = flt;
        vecs.push_back(r);
    endtask

    initial begin
        exp_t e;
        logic [5:0] got;

        // reset
        v(0,0,0,1,0, S_OFF,0); v(0,0,0,1,0, S_OFF,0);
        // start-up: request, parent ready, ack one clock behind enable
        v(1,1,0,1,0, S_REQ,0); v(1,1,0,0,0, S_REQ,0); v(1,1,0,0,0, S_REQ,0);
        v(1,1,1,0,0, S_ENA,0); v(1,1,1,0,1, S_ENA,0); v(1,1,1,0,1, S_ENA,0);
        v(1,1,1,0,1, S_ON,0);  v(1,1,1,0,1, S_ON,0);
        // orderly shutdown
        v(1,0,1,0,1, S_DIS,0); v(1,0,1,0,0, S_DIS,0); v(1,0,1,0,0, S_DIS,0);
        v(1,0,1,0,0, S_REL,0); v(1,0,0,0,0, S_REL,0); v(1,0,0,1,0, S_OFF,0);
        v(1,0,0,1,0, S_OFF,0);
        // one-cycle request pulse, parent never ready
        v(1,1,0,1,0, S_REQ,0); v(1,0,0,1,0, S_REL,0); v(1,0,0,0,0, S_REL,0);
        v(1,0,0,1,0, S_OFF,0);
        // parent lost while ON, then reset during DISABLING
        v(1,1,0,1,0, S_REQ,0); v(1,1,1,0,0, S_ENA,0); v(1,1,1,0,1, S_ENA,0);
        v(1,1,1,0,1, S_ENA,0); v(1,1,1,0,1, S_ON,0);  v(1,1,0,0,1, S_DIS,1);
        v(1,1,0,0,1, S_DIS,1); v(0,1,0,0,1, S_OFF,0); v(0,0,0,1,0, S_OFF,0);
        // ack never arrives: fault 8 cycles after entering ENABLING, state holds
        v(1,1,0,1,0, S_REQ,0); v(1,1,1,0,0, S_ENA,0);
        for (int i = 0; i < 7; i++) v(1,1,1,0,0, S_ENA,0);
        v(1,1,1,0,0, S_ENA,1);
        v(1,0,1,0,0, S_ENA,1);
        // late ack with request already dropped goes straight to DISABLING
        v(1,0,1,0,1, S_ENA,1); v(1,0,1,0,1, S_ENA,1); v(1,0,1,0,1, S_DIS,1);
        // request re-asserted during shutdown: completes to OFF, then restarts
        v(1,1,1,0,0, S_DIS,1); v(1,1,1,0,0, S_DIS,1); v(1,1,1,0,0, S_REL,1);
        v(1,1,0,1,0, S_OFF,1); v(1,1,0,1,0, S_REQ,1); v(1,0,0,1,0, S_REL,1);
        v(1,0,0,1,0, S_OFF,1);

        foreach (vecs[i]) begin
            @(negedge clock);
            resetn           = vecs[i].rstn;
            child_request    = vecs[i].creq;
            parent_ready     = vecs[i].pready;
            parent_silent    = vecs[i].psilent;
            async_enable_ack = vecs[i].ack;
            e.idx   = i;
            e.st    = vecs[i].st;
            e.flt   = vecs[i].flt;
            e.flags = exp_flags(vecs[i].st);
            sb.push_back(e);

            @(posedge clock);
            #1;
            e = sb.pop_front();
            got = {parent_request, async_enable, child_ready, child_silent,
                   child_starting, child_stopping};
            $display("row %0d: state=%0d fault=%0b flags=%b (exp state=%0d fault=%0b flags=%b)",
                     e.idx, state_dbg, fault, got, e.st, e.flt, e.flags);
            n_cmp++;
            if (state_dbg !== e.st) begin
                n_bad++;
                $display("FAIL state row %0d: got %0d, required %0d", e.idx, state_dbg, e.st);
            end
            n_cmp++;
            if (fault !== e.flt) begin
                n_bad++;
                $display("FAIL fault row %0d: got %0b, required %0b", e.idx, fault, e.flt);
            end
            n_cmp++;
            if (got !== e.flags) begin
                n_bad++;
                $display("FAIL flags row %0d: got %b, required %b", e.idx, got, e.flags);
            end
        end

        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries left, required 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
